// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC register and fetch handshake with branch redirect, multi-cycle flush and sticky misaligned-target trap.
// Optional accepted-redirect counter is built when PC_REDIRECT_CNT_EN is defined.
module pc_fetch_ctrl #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC     = 32'h0000_0000,
    parameter int unsigned      FLUSH_CYCLES = 2
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic            i_Branch_Mux,
    input  logic            i_Ex_Valid,
    input  logic [XLEN-1:0] iv_Branch_Target,
    input  logic            i_Stall,
    input  logic            i_Imem_Ready,
    output logic [XLEN-1:0] ov_PC,
    output logic            o_Fetch_Valid,
    output logic            o_Flush,
    output logic            o_Misaligned,
    output logic [31:0]     ov_Redirect_Cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic            flush_r;
    logic            misaligned_r;
    logic [3:0]      flush_cnt_r;

    logic            redirect_req_s;
    logic            redirect_acc_s;
    logic            target_aligned_s;
    logic            fetch_valid_s;
    logic            handshake_s;

    // Redirect qualification and fetch handshake decode
    always_comb begin
        redirect_req_s   = i_Ex_Valid && i_Branch_Mux;
        redirect_acc_s   = redirect_req_s && (state_r == ST_RUN);
        target_aligned_s = (iv_Branch_Target[1:0] == 2'b00);
        fetch_valid_s    = i_Rst_n && (state_r != ST_TRAP) && !i_Stall;
        handshake_s      = fetch_valid_s && i_Imem_Ready;
    end

    // Control FSM with PC, flush and trap registers
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_PC;
            flush_r      <= 1'b0;
            misaligned_r <= 1'b0;
            flush_cnt_r  <= 4'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_acc_s && target_aligned_s) begin
                        pc_r        <= iv_Branch_Target;
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= FLUSH_INIT;
                        flush_r     <= 1'b1;
                    end else if (redirect_acc_s) begin
                        state_r      <= ST_TRAP;
                        misaligned_r <= 1'b1;
                        flush_r      <= 1'b0;
                    end else if (i_Stall) begin
                        pc_r <= pc_r;
                    end else if (handshake_s) begin
                        pc_r <= pc_r + PC_STEP;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FLUSH: begin
                    // Redirects here come from killed instructions; the countdown ignores stalls.
                    if (!i_Stall && handshake_s) begin
                        pc_r <= pc_r + PC_STEP;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (flush_cnt_r <= 4'd1) begin
                        state_r     <= ST_RUN;
                        flush_r     <= 1'b0;
                        flush_cnt_r <= 4'd0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                        flush_r     <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    pc_r    <= pc_r;
                    flush_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_TRAP;
                    misaligned_r <= 1'b1;
                    flush_r      <= 1'b0;
                    flush_cnt_r  <= 4'd0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_r;

    // Saturating count of accepted aligned redirects
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            redirect_cnt_r <= 32'd0;
        end else if (redirect_acc_s && target_aligned_s &&
                     (redirect_cnt_r != 32'hFFFF_FFFF)) begin
            redirect_cnt_r <= redirect_cnt_r + 32'd1;
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    assign ov_Redirect_Cnt = redirect_cnt_r;
`else
    assign ov_Redirect_Cnt = 32'd0;
`endif

    assign ov_PC         = pc_r;
    assign o_Fetch_Valid = fetch_valid_s;
    assign o_Flush       = flush_r;
    assign o_Misaligned  = misaligned_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl: two instances (RESET_PC 0x100 and 0xFFFF_FFF8) share stimulus.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        branch_mux;
    logic        ex_valid;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_ready;

    logic [31:0] pc_a, pc_b;
    logic        fv_a, fv_b;
    logic        flush_a, flush_b;
    logic        mis_a, mis_b;
    logic [31:0] rcnt_a, rcnt_b;

    int checks   = 0;
    int failures = 0;

`ifdef PC_REDIRECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0100), .FLUSH_CYCLES(2)) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Branch_Mux(branch_mux), .i_Ex_Valid(ex_valid),
        .iv_Branch_Target(branch_target), .i_Stall(stall), .i_Imem_Ready(imem_ready),
        .ov_PC(pc_a), .o_Fetch_Valid(fv_a), .o_Flush(flush_a), .o_Misaligned(mis_a),
        .ov_Redirect_Cnt(rcnt_a)
    );

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(2)) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Branch_Mux(branch_mux), .i_Ex_Valid(ex_valid),
        .iv_Branch_Target(branch_target), .i_Stall(stall), .i_Imem_Ready(imem_ready),
        .ov_PC(pc_b), .o_Fetch_Valid(fv_b), .o_Flush(flush_b), .o_Misaligned(mis_b),
        .ov_Redirect_Cnt(rcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; ex_valid = 1'b0;
        branch_mux = 1'b0; branch_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL reset_fv cyc=%0d got=%b exp=0", i, fv_a); end
            checks++; if (pc_a !== 32'h100) begin failures++; $display("FAIL reset_pc cyc=%0d got=%h exp=00000100", i, pc_a); end
        end
        checks++; if ({flush_a, mis_a} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {flush_a, mis_a}); end
        checks++; if (rcnt_a !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", rcnt_a); end
        rst_n = 1'b1;
        #1;
        checks++; if (fv_a !== 1'b1 || pc_a !== 32'h100) begin failures++; $display("FAIL first_fetch fv=%b pc=%h exp fv=1 pc=00000100", fv_a, pc_a); end
        tick();
        checks++; if (pc_a !== 32'h104) begin failures++; $display("FAIL fetch_pc1 got=%h exp=00000104", pc_a); end
        tick();
        checks++; if (pc_a !== 32'h108) begin failures++; $display("FAIL fetch_pc2 got=%h exp=00000108", pc_a); end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (pc_a !== 32'h104) begin failures++; $display("FAIL bp_start got=%h exp=00000104", pc_a); end
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_a !== 32'h104 || fv_a !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d pc=%h fv=%b exp pc=00000104 fv=1", i, pc_a, fv_a); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (pc_a !== 32'h108) begin failures++; $display("FAIL bp_release got=%h exp=00000108", pc_a); end
    endtask

    task automatic test_redirect_flush();
        ex_valid = 1'b1; branch_mux = 1'b1; branch_target = 32'h200;
        tick();
        checks++; if (pc_a !== 32'h200 || flush_a !== 1'b1) begin failures++; $display("FAIL redir_taken pc=%h flush=%b exp pc=00000200 flush=1", pc_a, flush_a); end
        branch_target = 32'h300;
        tick();
        checks++; if (pc_a !== 32'h204 || flush_a !== 1'b1) begin failures++; $display("FAIL redir_ignored pc=%h flush=%b exp pc=00000204 flush=1", pc_a, flush_a); end
        ex_valid = 1'b0; branch_mux = 1'b0;
        tick();
        checks++; if (pc_a !== 32'h208 || flush_a !== 1'b0) begin failures++; $display("FAIL flush_end pc=%h flush=%b exp pc=00000208 flush=0", pc_a, flush_a); end
        checks++; if (rcnt_a !== (CNT_EN ? 32'd1 : 32'd0)) begin failures++; $display("FAIL redir_cnt1 got=%h exp=%h", rcnt_a, CNT_EN ? 32'd1 : 32'd0); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; ex_valid = 1'b1; branch_mux = 1'b1; branch_target = 32'h400;
        #1;
        checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL stall_fv_comb got=%b exp=0", fv_a); end
        tick();
        checks++; if (pc_a !== 32'h400 || flush_a !== 1'b1) begin failures++; $display("FAIL stall_redir pc=%h flush=%b exp pc=00000400 flush=1", pc_a, flush_a); end
        ex_valid = 1'b0; branch_mux = 1'b0;
        tick();
        checks++; if (pc_a !== 32'h400 || fv_a !== 1'b0 || flush_a !== 1'b1) begin failures++; $display("FAIL stall_hold1 pc=%h fv=%b flush=%b exp 00000400 0 1", pc_a, fv_a, flush_a); end
        tick();
        checks++; if (pc_a !== 32'h400 || flush_a !== 1'b0) begin failures++; $display("FAIL stall_hold2 pc=%h flush=%b exp 00000400 0", pc_a, flush_a); end
        stall = 1'b0;
        tick();
        checks++; if (pc_a !== 32'h404) begin failures++; $display("FAIL stall_release got=%h exp=00000404", pc_a); end
        checks++; if (rcnt_a !== (CNT_EN ? 32'd2 : 32'd0)) begin failures++; $display("FAIL redir_cnt2 got=%h exp=%h", rcnt_a, CNT_EN ? 32'd2 : 32'd0); end
    endtask

    task automatic test_misaligned();
        ex_valid = 1'b1; branch_mux = 1'b1; branch_target = 32'h202;
        tick();
        checks++; if (mis_a !== 1'b1 || fv_a !== 1'b0 || pc_a !== 32'h404 || flush_a !== 1'b0) begin failures++; $display("FAIL mis_enter mis=%b fv=%b pc=%h flush=%b exp 1 0 00000404 0", mis_a, fv_a, pc_a, flush_a); end
        branch_target = 32'h300;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mis_a !== 1'b1 || fv_a !== 1'b0 || pc_a !== 32'h404) begin failures++; $display("FAIL mis_sticky cyc=%0d mis=%b fv=%b pc=%h exp 1 0 00000404", i, mis_a, fv_a, pc_a); end
        end
        checks++; if (rcnt_a !== (CNT_EN ? 32'd2 : 32'd0)) begin failures++; $display("FAIL mis_cnt got=%h exp=%h", rcnt_a, CNT_EN ? 32'd2 : 32'd0); end
        ex_valid = 1'b0; branch_mux = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (mis_a !== 1'b0 || fv_a !== 1'b1 || pc_a !== 32'h100 || rcnt_a !== 32'd0) begin failures++; $display("FAIL mis_reset mis=%b fv=%b pc=%h cnt=%h exp 0 1 00000100 0", mis_a, fv_a, pc_a, rcnt_a); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (pc_b !== 32'hFFFF_FFF8 || fv_b !== 1'b1) begin failures++; $display("FAIL wrap_start pc=%h fv=%b exp FFFFFFF8 1", pc_b, fv_b); end
        tick();
        checks++; if (pc_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got=%h exp=FFFFFFFC", pc_b); end
        tick();
        checks++; if (pc_b !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc2 got=%h exp=00000000", pc_b); end
    endtask

    initial begin
        rst_n = 1'b0; branch_mux = 1'b0; ex_valid = 1'b0; branch_target = 32'h0;
        stall = 1'b0; imem_ready = 1'b1;
        test_reset();
        test_backpressure();
        test_redirect_flush();
        test_stall_redirect();
        test_misaligned();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
